vfpu_dutw_ctrl: RTL and testbench
=================================

Name: vfpu_dutw_ctrl

Overview:
- DUT-side end of the test/DUT-wrapper operand/result protocol.
- Accepts operand triples (`op_vld`, `operand_a/b/c`) from the test program and returns a registered echo (`op_vld_rx`, `operand_*_rx`) for stimulus checking.
- Buffers operands in a FIFO and issues them to the VFPU core through a req/gnt handshake.
- Returns core results as `res` / `res_rdy`, in issue order, with overflow and protocol-error flags for the scoreboard.

Parameters:
- DW, 32, operand/result width (single precision).
- FIFO_DEPTH, 8, operand FIFO entries (power of 2, ≥2).
- CNT_W, 16, width of accepted/returned op counters.

Ports:
- clk  in  1  clock; all logic is on the posedge.
- rst  in  1  synchronous, active-high reset.
- op_vld  in  1  operand triple valid this cycle; there is no backpressure.
- operand_a  in  DW  operand A.
- operand_b  in  DW  operand B.
- operand_c  in  DW  operand C.
- op_vld_rx  out  1  registered echo of op_vld.
- operand_a_rx  out  DW  registered echo of A.
- operand_b_rx  out  DW  registered echo of B.
- operand_c_rx  out  DW  registered echo of C.
- core_req  out  1  issue request to the core (FIFO non-empty).
- core_a  out  DW  FIFO head, operand A.
- core_b  out  DW  FIFO head, operand B.
- core_c  out  DW  FIFO head, operand C.
- core_gnt  in  1  core accepts the head this cycle.
- core_res  in  DW  core result.
- core_res_vld  in  1  core result valid.
- res  out  DW  result to the test program.
- res_rdy  out  1  one-cycle result strobe.
- ovf  out  1  sticky: an operand was dropped because the FIFO was full.
- perr  out  1  sticky: core_res_vld arrived with zero ops outstanding.
- acc_cnt  out  CNT_W  operand triples accepted into the FIFO.
- ret_cnt  out  CNT_W  results returned on res_rdy.

Behaviour:
- Reset (rst=1 at posedge): every output is 0.
  - FIFO pointers and outstanding counter are 0.
  - FSM goes to IDLE.
  - Reset mid-operation discards all queued and in-flight ops; core_res_vld in the reset cycle is ignored.
- Echo path, 1-cycle latency:
  - op_vld_rx <= op_vld.
  - operand_*_rx <= operand_* only when op_vld=1, otherwise hold.
  - The echo is independent of FIFO state; dropped ops are still echoed.
- Operand FIFO, first-word-fall-through:
  - push = op_vld & (!full | pop); pop = core_req & core_gnt.
  - Push and pop in the same cycle at full: both succeed and occupancy stays at FIFO_DEPTH.
  - Push and pop in the same cycle at empty: impossible, because core_req=0.
  - Pointers wrap modulo FIFO_DEPTH; full/empty use an extra pointer MSB.
  - op_vld with full & !pop: the op is dropped, ovf<=1 (sticky until rst), acc_cnt unchanged.
  - Issue latency: op_vld at cycle N gives core_req=1 with that op at head in cycle N+1.
- Core handshake:
  - core_req = !empty; core_a/b/c = head entry.
  - Head must stay stable while core_req=1 & core_gnt=0.
- Outstanding counter: width clog2(FIFO_DEPTH*4)+1.
  - Increments on pop, decrements on core_res_vld; both in the same cycle leave it unchanged.
  - core_res_vld with outstanding=0 (and no pop that cycle): result discarded, perr<=1, counter unchanged.
- Result path, 1-cycle latency:
  - On accepted core_res_vld: res <= core_res, res_rdy <= 1, ret_cnt += 1.
  - Otherwise res_rdy <= 0 and res holds its last value.
- acc_cnt and ret_cnt wrap modulo 2^CNT_W.
- FSM (status only; used for the drain assertion):
  - IDLE: FIFO empty and outstanding=0.
  - BUSY: FIFO non-empty or outstanding>0.
  - IDLE->BUSY on push; BUSY->IDLE when both conditions clear at the end of the cycle.
  - Assertion: in IDLE, acc_cnt == ret_cnt (ignoring wrap).

Decomposition:
- vfpu_dc_pkg holds:
  - DW;
  - typedef op_triple_t (struct packed {a,b,c});
  - typedef dutw_state_e {IDLE,BUSY}.
- Sub-module vfpu_op_fifo: parameterised FWFT FIFO of op_triple_t with push/pop/full/empty.
- FSM, counters and echo/result registers stay in vfpu_dutw_ctrl.

Test Plan:
- Echo: op_vld=1, a=0x3F800000, b=0x40000000, c=0x40400000 at cycle N -> op_vld_rx=1 and the same values at N+1; op_vld=0 at N+1 -> op_vld_rx=0 at N+2 and operand_*_rx held.
- Single op: push the triple above, core_gnt=1 in the next cycle, core returns core_res=0x40A00000 two cycles later -> core_req high 1 cycle, res=0x40A00000 with res_rdy one cycle after core_res_vld, acc_cnt=ret_cnt=1, FSM back to IDLE.
- Stall and full: core_gnt=0, 8 consecutive ops -> core_a stays at op0 throughout; 9th op -> dropped, ovf=1, acc_cnt=8; then 10th op in the same cycle as a gnt -> accepted, occupancy 8.
- Ordering and back-to-back: 20 ops, gnt always 1, core echoes a+1 per op -> 20 res_rdy pulses carrying values in issue order, no ovf, ret_cnt=20.
- Protocol error: core_res_vld=1 with nothing outstanding -> perr=1, no res_rdy, ret_cnt unchanged.
- Reset mid-flight: 3 ops queued and 2 outstanding, assert rst for 1 cycle -> all outputs 0, FIFO empty; a late core_res_vld after reset sets perr=1.

Source files
------------

// File: rtl/vfpu_dc_pkg.sv
// Shared types for the DUT-side wrapper of the VFPU operand/result protocol.
package vfpu_dc_pkg;

   localparam int DW = 32;

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [DW-1:0] c;
   } op_triple_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } dutw_state_e;

endpackage : vfpu_dc_pkg

// File: rtl/vfpu_op_fifo.sv
// First-word-fall-through FIFO of operand triples. Pointers carry one extra
// MSB so full and empty can be told apart when the index bits match.
// The caller is responsible for not pushing into a full FIFO unless it pops
// in the same cycle.
module vfpu_op_fifo
   import vfpu_dc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  op_triple_t               din_i,
   input  logic                     pop_i,
   output op_triple_t               dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   op_triple_t  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign count_o = wr_ptr_q - rd_ptr_q;
   assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values; index bits wrap naturally modulo DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   // Pointer registers, cleared by reset so all queued entries are discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write; contents need no reset since empty gates their use.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
   end

endmodule : vfpu_op_fifo

// File: rtl/vfpu_dutw_ctrl.sv
// DUT-side end of the test/DUT-wrapper protocol: echoes operands back to the
// test program, queues them for the VFPU core and returns results in order.
//
// Core handshake: an operand triple transfers on every posedge where
// core_req and core_gnt are both 1. While core_req=1 and core_gnt=0 the head
// (core_a/b/c) is held stable; core_req never drops without a transfer
// except on reset.
module vfpu_dutw_ctrl
   import vfpu_dc_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              op_vld,
   input  logic [DW-1:0]     operand_a,
   input  logic [DW-1:0]     operand_b,
   input  logic [DW-1:0]     operand_c,
   output logic              op_vld_rx,
   output logic [DW-1:0]     operand_a_rx,
   output logic [DW-1:0]     operand_b_rx,
   output logic [DW-1:0]     operand_c_rx,
   output logic              core_req,
   output logic [DW-1:0]     core_a,
   output logic [DW-1:0]     core_b,
   output logic [DW-1:0]     core_c,
   input  logic              core_gnt,
   input  logic [DW-1:0]     core_res,
   input  logic              core_res_vld,
   output logic [DW-1:0]     res,
   output logic              res_rdy,
   output logic              ovf,
   output logic              perr,
   output logic [CNT_W-1:0]  acc_cnt,
   output logic [CNT_W-1:0]  ret_cnt,
   output dutw_state_e       dbg_state_o
);

   localparam int OW = $clog2(FIFO_DEPTH * 4) + 1;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [OW-1:0]    OUT_ONE = {{(OW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0]    FCNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   op_triple_t      fifo_din, fifo_head;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count, fifo_count_d;
   logic            push, pop, res_acc, res_err, drop;

   logic            op_vld_rx_q;
   logic [DW-1:0]   opa_rx_q, opb_rx_q, opc_rx_q;
   logic [DW-1:0]   res_q;
   logic            res_rdy_q, ovf_q, perr_q;
   logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, ret_cnt_q, ret_cnt_d;
   logic [OW-1:0]   outst_q, outst_d;
   dutw_state_e     state_q, state_d;

   assign fifo_din = '{a: operand_a, b: operand_b, c: operand_c};

   vfpu_op_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .din_i   (fifo_din),
      .pop_i   (pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
   assign core_req = !fifo_empty;
   assign pop      = core_req & core_gnt;
   assign push     = op_vld & (!fifo_full | pop);
   assign drop     = op_vld & fifo_full & !pop;
   assign core_a   = fifo_empty ? '0 : fifo_head.a;
   assign core_b   = fifo_empty ? '0 : fifo_head.b;
   assign core_c   = fifo_empty ? '0 : fifo_head.c;

   // A result issued against an op popped this very cycle is legitimate.
   assign res_acc = core_res_vld & ((outst_q != '0) | pop);
   assign res_err = core_res_vld & !res_acc;

   // Next values of the in-flight counter, FIFO occupancy and op counters.
   always_comb begin
      outst_d      = outst_q;
      fifo_count_d = fifo_count;
      acc_cnt_d    = acc_cnt_q;
      ret_cnt_d    = ret_cnt_q;
      if (pop && !res_acc)  outst_d = outst_q + OUT_ONE;
      if (!pop && res_acc)  outst_d = outst_q - OUT_ONE;
      if (push)             fifo_count_d = fifo_count_d + FCNT_ONE;
      if (pop)              fifo_count_d = fifo_count_d - FCNT_ONE;
      if (push)             acc_cnt_d = acc_cnt_q + CNT_ONE;
      if (res_acc)          ret_cnt_d = ret_cnt_q + CNT_ONE;
   end

   // Status FSM: BUSY while anything is queued or in flight.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (push) state_d = BUSY;
         BUSY:    if (fifo_count_d == '0 && outst_d == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered state: echo, result, sticky flags, counters and FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_vld_rx_q <= 1'b0;
         opa_rx_q    <= '0;
         opb_rx_q    <= '0;
         opc_rx_q    <= '0;
         res_q       <= '0;
         res_rdy_q   <= 1'b0;
         ovf_q       <= 1'b0;
         perr_q      <= 1'b0;
         acc_cnt_q   <= '0;
         ret_cnt_q   <= '0;
         outst_q     <= '0;
         state_q     <= IDLE;
      end else begin
         op_vld_rx_q <= op_vld;
         if (op_vld) begin
            opa_rx_q <= operand_a;
            opb_rx_q <= operand_b;
            opc_rx_q <= operand_c;
         end
         res_rdy_q <= res_acc;
         if (res_acc) res_q <= core_res;
         if (drop)    ovf_q <= 1'b1;
         if (res_err) perr_q <= 1'b1;
         acc_cnt_q <= acc_cnt_d;
         ret_cnt_q <= ret_cnt_d;
         outst_q   <= outst_d;
         state_q   <= state_d;
      end
   end

   assign op_vld_rx    = op_vld_rx_q;
   assign operand_a_rx = opa_rx_q;
   assign operand_b_rx = opb_rx_q;
   assign operand_c_rx = opc_rx_q;
   assign res          = res_q;
   assign res_rdy      = res_rdy_q;
   assign ovf          = ovf_q;
   assign perr         = perr_q;
   assign acc_cnt      = acc_cnt_q;
   assign ret_cnt      = ret_cnt_q;
   assign dbg_state_o  = state_q;

   // When fully drained, every accepted op must have produced a result.
   a_idle_drained: assert property (@(posedge clk) disable iff (rst)
      (state_q == IDLE) |-> (acc_cnt_q == ret_cnt_q));

endmodule : vfpu_dutw_ctrl

// File: tb/tb_vfpu_dutw_ctrl.sv
// Directed bench for vfpu_dutw_ctrl: echo, single op, stall/full, ordering,
// protocol error and reset mid-flight.
module tb_vfpu_dutw_ctrl;
   import vfpu_dc_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              op_vld;
   logic [DW-1:0]     operand_a, operand_b, operand_c;
   logic              op_vld_rx;
   logic [DW-1:0]     operand_a_rx, operand_b_rx, operand_c_rx;
   logic              core_req;
   logic [DW-1:0]     core_a, core_b, core_c;
   logic              core_gnt;
   logic [DW-1:0]     core_res;
   logic              core_res_vld;
   logic [DW-1:0]     res;
   logic              res_rdy, ovf, perr;
   logic [15:0]       acc_cnt, ret_cnt;
   dutw_state_e       dbg_state;

   int n_chk = 0;
   int n_bad = 0;
   logic [DW-1:0] exp_q[$];

   vfpu_dutw_ctrl #(.FIFO_DEPTH(8), .CNT_W(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .op_vld       (op_vld),
      .operand_a    (operand_a),
      .operand_b    (operand_b),
      .operand_c    (operand_c),
      .op_vld_rx    (op_vld_rx),
      .operand_a_rx (operand_a_rx),
      .operand_b_rx (operand_b_rx),
      .operand_c_rx (operand_c_rx),
      .core_req     (core_req),
      .core_a       (core_a),
      .core_b       (core_b),
      .core_c       (core_c),
      .core_gnt     (core_gnt),
      .core_res     (core_res),
      .core_res_vld (core_res_vld),
      .res          (res),
      .res_rdy      (res_rdy),
      .ovf          (ovf),
      .perr         (perr),
      .acc_cnt      (acc_cnt),
      .ret_cnt      (ret_cnt),
      .dbg_state_o  (dbg_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Driver tasks: inputs change and outputs are sampled 1 time unit after posedge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      op_vld = 1'b0; operand_a = '0; operand_b = '0; operand_c = '0;
      core_gnt = 1'b0; core_res = '0; core_res_vld = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
   endtask

   task automatic drive_op(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
      op_vld = 1'b1; operand_a = a; operand_b = b; operand_c = c;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      int pulses;
      logic pend_vld, nxt_vld;
      logic [DW-1:0] pend_val, nxt_val;

      // ---------- reset state ----------
      do_reset();
      chk("rst_op_vld_rx", 32'(op_vld_rx), 32'd0);
      chk("rst_a_rx", operand_a_rx, 32'd0);
      chk("rst_core_req", 32'(core_req), 32'd0);
      chk("rst_core_a", core_a, 32'd0);
      chk("rst_res", res, 32'd0);
      chk("rst_res_rdy", 32'(res_rdy), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_perr", 32'(perr), 32'd0);
      chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
      chk("rst_ret_cnt", 32'(ret_cnt), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);

      // ---------- echo ----------
      drive_op(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
      step();
      chk("echo_vld", 32'(op_vld_rx), 32'd1);
      chk("echo_a", operand_a_rx, 32'h3F80_0000);
      chk("echo_b", operand_b_rx, 32'h4000_0000);
      chk("echo_c", operand_c_rx, 32'h4040_0000);
      op_vld = 1'b0; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1; operand_c = 32'h2;
      step();
      chk("echo_vld_low", 32'(op_vld_rx), 32'd0);
      chk("echo_a_hold", operand_a_rx, 32'h3F80_0000);
      chk("echo_c_hold", operand_c_rx, 32'h4040_0000);

      // ---------- single op ----------
      do_reset();
      drive_op(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
      step();
      chk("single_req", 32'(core_req), 32'd1);
      chk("single_core_a", core_a, 32'h3F80_0000);
      chk("single_core_c", core_c, 32'h4040_0000);
      chk("single_acc", 32'(acc_cnt), 32'd1);
      op_vld = 1'b0; core_gnt = 1'b1;
      step();
      chk("single_req_drop", 32'(core_req), 32'd0);
      chk("single_busy", 32'(dbg_state), 32'd1);
      core_gnt = 1'b0;
      step();
      core_res_vld = 1'b1; core_res = 32'h40A0_0000;
      step();
      chk("single_res_rdy", 32'(res_rdy), 32'd1);
      chk("single_res", res, 32'h40A0_0000);
      chk("single_ret", 32'(ret_cnt), 32'd1);
      chk("single_idle", 32'(dbg_state), 32'd0);
      core_res_vld = 1'b0; core_res = 32'h0;
      step();
      chk("single_rdy_low", 32'(res_rdy), 32'd0);
      chk("single_res_hold", res, 32'h40A0_0000);

      // ---------- stall and full ----------
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive_op(32'h100 + 32'(i), 32'h200 + 32'(i), 32'h300 + 32'(i));
         step();
         chk("stall_head", core_a, 32'h100);
      end
      chk("stall_acc8", 32'(acc_cnt), 32'd8);
      chk("stall_no_ovf", 32'(ovf), 32'd0);
      drive_op(32'h108, 32'h208, 32'h308);
      step();
      chk("full_ovf", 32'(ovf), 32'd1);
      chk("full_acc", 32'(acc_cnt), 32'd8);
      chk("full_head", core_a, 32'h100);
      drive_op(32'h109, 32'h209, 32'h309);
      core_gnt = 1'b1;
      step();
      chk("full_pushpop_acc", 32'(acc_cnt), 32'd9);
      chk("full_ovf_sticky", 32'(ovf), 32'd1);
      op_vld = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("drain_req", 32'(core_req), 32'd1);
         chk("drain_a", core_a, (k < 7) ? 32'h101 + 32'(k) : 32'h109);
         step();
      end
      chk("drain_empty", 32'(core_req), 32'd0);
      core_gnt = 1'b0;

      // ---------- ordering, back-to-back ----------
      do_reset();
      pulses = 0;
      pend_vld = 1'b0; pend_val = '0;
      for (int i = 0; i < 30; i++) begin
         if (i < 20) begin
            drive_op(32'h4000_0000 + 32'(i * 3), 32'(i), 32'(i + 100));
            exp_q.push_back(32'h4000_0000 + 32'(i * 3) + 32'd1);
         end else begin
            op_vld = 1'b0;
         end
         core_gnt     = 1'b1;
         core_res_vld = pend_vld;
         core_res     = pend_val;
         nxt_vld      = core_req;
         nxt_val      = core_a + 32'd1;
         step();
         if (res_rdy) begin
            pulses++;
            if (exp_q.size() == 0) chk("order_extra_res", res, 32'hFFFF_FFFF);
            else chk("order_res", res, exp_q.pop_front());
         end
         pend_vld = nxt_vld;
         pend_val = nxt_val;
      end
      idle_inputs();
      chk("order_pulses", 32'(pulses), 32'd20);
      chk("order_q_empty", 32'(exp_q.size()), 32'd0);
      chk("order_ret", 32'(ret_cnt), 32'd20);
      chk("order_acc", 32'(acc_cnt), 32'd20);
      chk("order_no_ovf", 32'(ovf), 32'd0);
      chk("order_no_perr", 32'(perr), 32'd0);
      chk("order_idle", 32'(dbg_state), 32'd0);

      // ---------- protocol error ----------
      do_reset();
      core_res_vld = 1'b1; core_res = 32'h1234_5678;
      step();
      core_res_vld = 1'b0;
      chk("perr_set", 32'(perr), 32'd1);
      chk("perr_no_rdy", 32'(res_rdy), 32'd0);
      chk("perr_ret", 32'(ret_cnt), 32'd0);
      chk("perr_res", res, 32'd0);

      // ---------- reset mid-flight ----------
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_op(32'h500 + 32'(i), 32'h0, 32'h0);
         step();
      end
      op_vld = 1'b0; core_gnt = 1'b1;
      step(); step();
      core_gnt = 1'b0;
      chk("mid_head", core_a, 32'h502);
      chk("mid_busy", 32'(dbg_state), 32'd1);
      rst = 1'b1; core_res_vld = 1'b1; core_res = 32'hABCD_0000;
      step();
      rst = 1'b0; core_res_vld = 1'b0;
      chk("mid_req", 32'(core_req), 32'd0);
      chk("mid_core_a", core_a, 32'd0);
      chk("mid_acc", 32'(acc_cnt), 32'd0);
      chk("mid_res_rdy", 32'(res_rdy), 32'd0);
      chk("mid_res", res, 32'd0);
      chk("mid_perr", 32'(perr), 32'd0);
      chk("mid_state", 32'(dbg_state), 32'd0);
      core_res_vld = 1'b1; core_res = 32'hABCD_0001;
      step();
      core_res_vld = 1'b0;
      chk("late_perr", 32'(perr), 32'd1);
      chk("late_no_rdy", 32'(res_rdy), 32'd0);
      chk("late_ret", 32'(ret_cnt), 32'd0);

      // ---------- report ----------
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule : tb_vfpu_dutw_ctrl
